tri_st_rot_mrg64: RTL and testbench

//  Mask/merge stage directly downstream of the 64-bit rotator in the simple-FXU rotate path.

---
 rtl/tri_st_rot_mrg64.sv | 241 ++++++++++++++++++++++++
 tb/tb_tri_st_rot_mrg64.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_st_rot_mrg64.sv
// -----------------------------------------------------------------------------
// tri_st_rot_mrg64
//
// Purpose
//   Mask/merge stage that sits directly after the 64-bit rotator in the
//   simple-FXU rotate path. It takes the rotated operand and builds the MB..ME
//   mask, which may wrap around. It then merges the rotated data with one of
//   three fill sources (zeros, insert data, or sign fill). The stage produces
//   the rldic*/rlw*/sld/srd/srad result, the CA bit and a zero flag.
//
//   The stage is a two-register pipeline with valid/ready flow control and a
//   flush:
//     stage A : captures the raw operation on accept
//     stage B : holds the merged result, CA and zero flag; it drives out_*
//   Latency from accept to out_val is 2 cycles when the pipe is not stalled.
//   Throughput is one operation per cycle.
//
// Bit numbering
//   The rotator uses big-endian numbering, where bit 0 is the MSB. The vectors
//   here are declared [63:0], so big-endian bit i is vector bit [63-i]. MB and
//   ME are big-endian indices.
//
// Parameters
//   TAG_W         width of the opaque tag (ITAG / thread id) carried with data
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   flush         kills every in-flight op at the next edge
//   in_val        input op valid
//   in_rdy        stage can accept; transfer when in_val & in_rdy
//   in_rot        rotator output
//   in_mb, in_me  mask begin / end (big-endian bit index)
//   in_mask_zero  force an all-zero mask (shift amount out of range)
//   in_ins_sel    fill for unmasked bits: 00 zero, 01 insert data,
//                 10 sign fill, 11 zero
//   in_ins_data   insert operand (rlwimi/rldimi RA)
//   in_sign       source sign for algebraic shifts
//   in_ca_en      op writes CA
//   in_tag        op tag
//   out_val       result valid
//   out_rdy       consumer accepts; transfer when out_val & out_rdy
//   out_res       merged result
//   out_ca        carry (0 unless the op is CA-enabled)
//   out_zero      out_res == 0
//   out_tag       tag belonging to out_res
// -----------------------------------------------------------------------------
module tri_st_rot_mrg64 #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             in_val,
  output logic             in_rdy,
  input  logic [63:0]      in_rot,
  input  logic [5:0]       in_mb,
  input  logic [5:0]       in_me,
  input  logic             in_mask_zero,
  input  logic [1:0]       in_ins_sel,
  input  logic [63:0]      in_ins_data,
  input  logic             in_sign,
  input  logic             in_ca_en,
  input  logic [TAG_W-1:0] in_tag,

  output logic             out_val,
  input  logic             out_rdy,
  output logic [63:0]      out_res,
  output logic             out_ca,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Fill-select encodings
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_INS  = 2'b01;
  localparam logic [1:0] SEL_SIGN = 2'b10;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             r_a_val;
  logic [63:0]      r_a_rot;
  logic [5:0]       r_a_mb;
  logic [5:0]       r_a_me;
  logic             r_a_mask_zero;
  logic [1:0]       r_a_ins_sel;
  logic [63:0]      r_a_ins_data;
  logic             r_a_sign;
  logic             r_a_ca_en;
  logic [TAG_W-1:0] r_a_tag;

  logic             r_b_val;
  logic [63:0]      r_b_res;
  logic             r_b_ca;
  logic             r_b_zero;
  logic [TAG_W-1:0] r_b_tag;

  // ---------------------------------------------------------------------------
  // Flow control
  //   A stage advances when it is empty or when B can take its contents.
  //   in_rdy does not depend on in_val or flush, so it stays a clean
  //   register-derived term.
  // ---------------------------------------------------------------------------
  logic w_b_adv;
  logic w_a_adv;
  logic w_a_load;
  logic w_b_load;

  assign w_b_adv  = ~r_b_val | out_rdy;
  assign w_a_adv  = ~r_a_val | w_b_adv;
  assign w_a_load = in_val & w_a_adv;
  assign w_b_load = r_a_val & w_b_adv;

  assign in_rdy   = w_a_adv;

  // ---------------------------------------------------------------------------
  // Mask generation from the A registers.
  //   The mask is wrapped when mb > me: it covers the bits at or after mb
  //   together with the bits at or before me. Otherwise the mask is the
  //   closed range mb..me. When mb == me, this range is a single bit.
  // ---------------------------------------------------------------------------
  logic        w_wrap;
  logic [63:0] w_mask;

  assign w_wrap = (r_a_mb > r_a_me);

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_mask
      localparam logic [5:0] IDX = 6'(gi);
      logic w_ge_mb;
      logic w_le_me;
      assign w_ge_mb = (IDX >= r_a_mb);
      assign w_le_me = (IDX <= r_a_me);
      // Big-endian bit gi is vector bit 63-gi.
      assign w_mask[63-gi] = ~r_a_mask_zero &
                             (w_wrap ? (w_ge_mb | w_le_me) : (w_ge_mb & w_le_me));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fill selection and merge
  // ---------------------------------------------------------------------------
  logic [63:0] w_fill;
  logic [63:0] w_res;
  logic        w_ca;
  logic        w_zero;

  always_comb begin
    w_fill = '0;
    case (r_a_ins_sel)
      SEL_ZERO: w_fill = '0;
      SEL_INS:  w_fill = r_a_ins_data;
      SEL_SIGN: w_fill = {64{r_a_sign}};
      default:  w_fill = '0;   // reserved encoding behaves as zero fill
    endcase
  end

  assign w_res  = (r_a_rot & w_mask) | (w_fill & ~w_mask);

  // CA is set when a negative source shifts out one-bits. The shifted-out bits
  // are the rotated bits that fall outside the mask.
  assign w_ca   = r_a_ca_en & r_a_sign & (|(r_a_rot & ~w_mask));

  // The zero flag is computed here, before the B register, so that it
  // arrives together with the result.
  assign w_zero = ~(|w_res);

  // ---------------------------------------------------------------------------
  // Valid bits.
  //   Flush clears both stages at the next edge. An op offered on in_val
  //   during the flush cycle is dropped because A is cleared, not loaded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_val <= 1'b0;
      r_b_val <= 1'b0;
    end else if (flush) begin
      r_a_val <= 1'b0;
      r_b_val <= 1'b0;
    end else begin
      if (w_a_adv) r_a_val <= in_val;
      if (w_b_adv) r_b_val <= r_a_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage A data: loads only on accept and holds while stalled.
  // Flush does not need to gate this load, because the valid bit is cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rot       <= '0;
      r_a_mb        <= '0;
      r_a_me        <= '0;
      r_a_mask_zero <= 1'b0;
      r_a_ins_sel   <= '0;
      r_a_ins_data  <= '0;
      r_a_sign      <= 1'b0;
      r_a_ca_en     <= 1'b0;
      r_a_tag       <= '0;
    end else if (w_a_load) begin
      r_a_rot       <= in_rot;
      r_a_mb        <= in_mb;
      r_a_me        <= in_me;
      r_a_mask_zero <= in_mask_zero;
      r_a_ins_sel   <= in_ins_sel;
      r_a_ins_data  <= in_ins_data;
      r_a_sign      <= in_sign;
      r_a_ca_en     <= in_ca_en;
      r_a_tag       <= in_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B data: these registers drive the outputs directly. Reset clears
  // them, so every output reads 0 while reset is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_res  <= '0;
      r_b_ca   <= 1'b0;
      r_b_zero <= 1'b0;
      r_b_tag  <= '0;
    end else if (w_b_load) begin
      r_b_res  <= w_res;
      r_b_ca   <= w_ca;
      r_b_zero <= w_zero;
      r_b_tag  <= r_a_tag;
    end
  end

  assign out_val  = r_b_val;
  assign out_res  = r_b_res;
  assign out_ca   = r_b_ca;
  assign out_zero = r_b_zero;
  assign out_tag  = r_b_tag;

endmodule

// File: tb/tb_tri_st_rot_mrg64.sv
// -----------------------------------------------------------------------------
// Testbench for tri_st_rot_mrg64.
//
// Timing scheme
//   Stimulus is driven 1 time unit after each rising edge.
//   Output transfers are checked on the falling edge.
//   Accepted ops are recorded 1 time unit after the falling edge.
//
// Checking
//   Accepted ops push their expected result into a scoreboard queue. The
//   expected value is either a literal for the directed vectors or comes from
//   the reference model. A monitor pops the queue on every output transfer.
//   Flush and reset discard the queued entries.
// -----------------------------------------------------------------------------
module tb_tri_st_rot_mrg64;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_val;
  logic             in_rdy;
  logic [63:0]      in_rot;
  logic [5:0]       in_mb;
  logic [5:0]       in_me;
  logic             in_mask_zero;
  logic [1:0]       in_ins_sel;
  logic [63:0]      in_ins_data;
  logic             in_sign;
  logic             in_ca_en;
  logic [TAG_W-1:0] in_tag;
  logic             out_val;
  logic             out_rdy;
  logic [63:0]      out_res;
  logic             out_ca;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  tri_st_rot_mrg64 #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_rot       (in_rot),
    .in_mb        (in_mb),
    .in_me        (in_me),
    .in_mask_zero (in_mask_zero),
    .in_ins_sel   (in_ins_sel),
    .in_ins_data  (in_ins_data),
    .in_sign      (in_sign),
    .in_ca_en     (in_ca_en),
    .in_tag       (in_tag),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_res      (out_res),
    .out_ca       (out_ca),
    .out_zero     (out_zero),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      res;
    logic             ca;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  logic [TAG_W-1:0] tag_cnt = '0;

  // Literal expectation for a directed vector. When d_use is clear, the
  // expectation comes from the reference model instead.
  logic        d_use  = 1'b0;
  logic [63:0] d_res  = '0;
  logic        d_ca   = 1'b0;
  logic        d_zero = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model.
  // Big-endian bit i is value bit 63-i. The range mb..me is therefore the
  // value bits at or below 63-mb that are also at or above 63-me.
  function automatic exp_t model(input logic [63:0] rot, input logic [5:0] mb,
                                 input logic [5:0] me, input logic mz,
                                 input logic [1:0] sel, input logic [63:0] ins,
                                 input logic sign, input logic ca_en,
                                 input logic [TAG_W-1:0] tag);
    logic [63:0] ones;
    logic [63:0] from_mb;
    logic [63:0] to_me;
    logic [63:0] mask;
    logic [63:0] fill;
    exp_t e;
    ones    = '1;
    from_mb = ones >> mb;
    to_me   = ones << (6'd63 - me);
    mask    = (mb <= me) ? (from_mb & to_me) : (from_mb | to_me);
    if (mz) mask = '0;
    if (sel == 2'b01)      fill = ins;
    else if (sel == 2'b10) fill = {64{sign}};
    else                   fill = '0;
    e.res  = (rot & mask) | (fill & ~mask);
    e.ca   = ca_en & sign & (|(rot & ~mask));
    e.zero = (e.res == 64'd0);
    e.tag  = tag;
    return e;
  endfunction

  // Monitor: compares every output transfer against the head of the queue.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_val && out_rdy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got tag %0d res %h want no output", out_tag, out_res);
        end else begin
          e = q.pop_front();
          $display("tb: out tag=%0d res=%h ca=%0d zero=%0d", out_tag, out_res, out_ca, out_zero);
          chk("res",  out_res,         e.res);
          chk("ca",   64'(out_ca),     64'(e.ca));
          chk("zero", 64'(out_zero),   64'(e.zero));
          chk("tag",  64'(out_tag),    64'(e.tag));
        end
      end
    end
  endtask

  // Tracker: records accepted ops and discards everything on flush or reset.
  task automatic tracker();
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst || flush) begin
        q.delete();
      end else if (in_val && in_rdy) begin
        e = model(in_rot, in_mb, in_me, in_mask_zero, in_ins_sel, in_ins_data,
                  in_sign, in_ca_en, in_tag);
        if (d_use) begin
          e.res  = d_res;
          e.ca   = d_ca;
          e.zero = d_zero;
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic set_op(input logic [63:0] rot, input logic [5:0] mb, input logic [5:0] me,
                        input logic mz, input logic [1:0] sel, input logic [63:0] ins,
                        input logic sign, input logic ca_en);
    in_rot       = rot;
    in_mb        = mb;
    in_me        = me;
    in_mask_zero = mz;
    in_ins_sel   = sel;
    in_ins_data  = ins;
    in_sign      = sign;
    in_ca_en     = ca_en;
    in_tag       = tag_cnt;
    tag_cnt      = tag_cnt + 1'b1;
  endtask

  // Holds in_val until the op is accepted. Called 1 unit after a rising edge;
  // returns 1 unit after the accepting edge.
  task automatic send_op();
    logic acc;
    acc = 1'b0;
    in_val = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
    end
    in_val = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_rdy 0 want 1 within 50 cycles");
    end
  endtask

  task automatic send_dir(input logic [63:0] rot, input logic [5:0] mb, input logic [5:0] me,
                          input logic mz, input logic [1:0] sel, input logic [63:0] ins,
                          input logic sign, input logic ca_en,
                          input logic [63:0] xres, input logic xca, input logic xzero);
    set_op(rot, mb, me, mz, sel, ins, sign, ca_en);
    d_use  = 1'b1;
    d_res  = xres;
    d_ca   = xca;
    d_zero = xzero;
    send_op();
    d_use  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    set_op('0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
    tag_cnt = '0;
    fork
      monitor();
      tracker();
    join_none

    cycles(2);
    // Reset state
    chk("rst_out_val",  64'(out_val),  64'd0);
    chk("rst_out_res",  out_res,       64'd0);
    chk("rst_out_ca",   64'(out_ca),   64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_tag",  64'(out_tag),  64'd0);
    chk("rst_in_rdy",   64'(in_rdy),   64'd1);
    rst = 1'b0;
    out_rdy = 1'b1;
    cycles(1);

    // rlwinm-style vector, with a latency check
    send_dir(64'h0000_0000_1234_5678, 6'd48, 6'd63, 1'b0, 2'b00, '0, 1'b0, 1'b0,
             64'h0000_0000_0000_5678, 1'b0, 1'b0);
    chk("lat_1cyc_out_val", 64'(out_val), 64'd0);
    cycles(1);
    chk("lat_2cyc_out_val", 64'(out_val), 64'd1);

    // Wrapped mask
    send_dir(64'hFFFF_FFFF_FFFF_FFFF, 6'd60, 6'd3, 1'b0, 2'b01, '0, 1'b0, 1'b0,
             64'hF000_0000_0000_000F, 1'b0, 1'b0);
    // srad with one-bits shifted out: CA=1
    send_dir(64'hF000_0000_0000_0001, 6'd3, 6'd63, 1'b0, 2'b10, '0, 1'b1, 1'b1,
             64'hF000_0000_0000_0001, 1'b1, 1'b0);
    // srad with no one-bits shifted out: CA=0
    send_dir(64'h1000_0000_0000_0001, 6'd3, 6'd63, 1'b0, 2'b10, '0, 1'b1, 1'b1,
             64'hF000_0000_0000_0001, 1'b0, 1'b0);
    // CA suppressed when ca_en=0
    send_dir(64'hF000_0000_0000_0001, 6'd3, 6'd63, 1'b0, 2'b10, '0, 1'b1, 1'b0,
             64'hF000_0000_0000_0001, 1'b0, 1'b0);
    // mask_zero with sign fill
    send_dir(64'h1234_5678_9ABC_DEF0, 6'd0, 6'd63, 1'b1, 2'b10, '0, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_dir(64'h1234_5678_9ABC_DEF0, 6'd0, 6'd63, 1'b1, 2'b10, '0, 1'b0, 1'b0,
             64'h0000_0000_0000_0000, 1'b0, 1'b1);
    // Reserved fill select behaves as zeros
    send_dir(64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 6'd7, 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
             64'hFF00_0000_0000_0000, 1'b0, 1'b0);
    // Single-bit mask (mb == me)
    send_dir(64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 6'd5, 1'b0, 2'b00, '0, 1'b0, 1'b0,
             64'h0400_0000_0000_0000, 1'b0, 1'b0);
    cycles(4);

    // Backpressure: 4 ops with out_rdy low for 3 cycles
    fork
      begin
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_rdy = 1'b1;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          set_op({$urandom, $urandom}, 6'($urandom), 6'($urandom), 1'b0,
                 2'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
          send_op();
          if (k == 1) begin
            @(negedge clk);
            chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
          end
        end
      end
    join
    cycles(6);

    // Flush with A and B full plus an op on in_val
    out_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_op({$urandom, $urandom}, 6'd0, 6'd63, 1'b0, 2'b00, '0, 1'b0, 1'b0);
      send_op();
    end
    set_op({$urandom, $urandom}, 6'd0, 6'd63, 1'b0, 2'b00, '0, 1'b0, 1'b0);
    in_val = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    chk("flush_pre_out_val", 64'(out_val), 64'd1);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    in_val = 1'b0;
    chk("flush_post_out_val", 64'(out_val), 64'd0);
    chk("flush_post_in_rdy",  64'(in_rdy),  64'd1);
    out_rdy = 1'b1;
    cycles(5);
    chk("flush_no_stale", 64'(out_val), 64'd0);

    // Randomized traffic with random backpressure and occasional flush
    for (int c = 0; c < 500; c++) begin
      set_op({$urandom, $urandom}, 6'($urandom), 6'($urandom),
             ($urandom_range(0, 7) == 0), 2'($urandom), {$urandom, $urandom},
             1'($urandom), 1'($urandom));
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      cycles(1);
    end
    in_val = 1'b0;
    flush  = 1'b0;
    out_rdy = 1'b1;
    cycles(5);

    // Asynchronous reset in the middle of a stalled stream
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_op({$urandom, $urandom}, 6'd3, 6'd63, 1'b0, 2'b10, '0, 1'b1, 1'b1);
      in_val = 1'b1;
      cycles(1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_val",  64'(out_val),  64'd0);
    chk("arst_out_res",  out_res,       64'd0);
    chk("arst_out_ca",   64'(out_ca),   64'd0);
    chk("arst_out_zero", 64'(out_zero), 64'd0);
    chk("arst_out_tag",  64'(out_tag),  64'd0);
    chk("arst_in_rdy",   64'(in_rdy),   64'd1);
    in_val = 1'b0;
    cycles(2);
    rst = 1'b0;
    out_rdy = 1'b1;
    cycles(5);
    chk("arst_no_emit", 64'(out_val), 64'd0);

    // Short random burst after reset, then drain
    for (int c = 0; c < 40; c++) begin
      set_op({$urandom, $urandom}, 6'($urandom), 6'($urandom), 1'b0,
             2'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      in_val  = ($urandom_range(0, 1) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      cycles(1);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) cycles(1);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
